// File: rtl/event_encoder_8_3.sv
// Sequential 8-to-3 event encoder: sticky pending capture, fixed-priority
// selection, one index per valid/ready handshake, saturating overrun counter.
module event_encoder_8_3 #(
  parameter int LSB_PRIORITY = 1,
  parameter int CNT_W        = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       In,
  input  logic             Ready,
  output logic [2:0]       Out,
  output logic             Valid,
  output logic [7:0]       Pending,
  output logic             Overrun,
  output logic [CNT_W-1:0] OverrunCount
);

  logic [7:0]       pend_p0;
  logic [2:0]       out_p1;
  logic             vld_p1;
  logic             ovr_p1;
  logic [CNT_W-1:0] ocnt_p1;

  logic             load;
  logic [3:0]       sel;
  logic [7:0]       clr_mask;
  logic             ovr_hit;

  // Returns {found, index} of the highest-priority set bit of m.
  function automatic logic [3:0] pick(input logic [7:0] m);
    logic [3:0] r;
    r = 4'd0;
    if (LSB_PRIORITY != 0) begin
      for (int k = 7; k >= 0; k--)
        if (m[k]) r = {1'b1, 3'(k)};
    end else begin
      for (int k = 0; k < 8; k++)
        if (m[k]) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: selection from the registered pending mask only
  always_comb begin
    load     = !vld_p1 || Ready;
    sel      = pick(pend_p0);
    clr_mask = 8'd0;
    if (load && sel[3])
      clr_mask = 8'b1 << sel[2:0];
    ovr_hit  = |(In & pend_p0 & ~clr_mask);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_p0 <= 8'd0;
    end else begin
      // A new request in the same cycle as its clear keeps the bit pending.
      pend_p0 <= (pend_p0 & ~clr_mask) | In;
    end
  end

  // Stage p1: presented index, valid and overrun reporting
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_p1  <= 3'd0;
      vld_p1  <= 1'b0;
      ovr_p1  <= 1'b0;
      ocnt_p1 <= '0;
    end else begin
      if (load) begin
        vld_p1 <= sel[3];
        if (sel[3])
          out_p1 <= sel[2:0];
      end
      ovr_p1 <= ovr_hit;
      if (ovr_hit)
        ocnt_p1 <= sat_inc(ocnt_p1);
    end
  end

  assign Out          = out_p1;
  assign Valid        = vld_p1;
  assign Pending      = pend_p0;
  assign Overrun      = ovr_p1;
  assign OverrunCount = ocnt_p1;

endmodule

// File: tb/tb_event_encoder_8_3.sv
// Bench for event_encoder_8_3: LSB-first and MSB-first instances on shared
// stimulus, checked against a behavioural model plus directed literal checks.
module tb_event_encoder_8_3;

  logic       clk;
  logic       rst;
  logic [7:0] in_req;
  logic       ready;

  logic [2:0] out_a, out_b;
  logic       vld_a, vld_b;
  logic [7:0] pend_a, pend_b;
  logic       ovr_a, ovr_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  event_encoder_8_3 #(.LSB_PRIORITY(1), .CNT_W(8)) dut_a (
    .Clk(clk), .Reset(rst), .In(in_req), .Ready(ready),
    .Out(out_a), .Valid(vld_a), .Pending(pend_a),
    .Overrun(ovr_a), .OverrunCount(cnt_a)
  );

  event_encoder_8_3 #(.LSB_PRIORITY(0), .CNT_W(8)) dut_b (
    .Clk(clk), .Reset(rst), .In(in_req), .Ready(ready),
    .Out(out_b), .Valid(vld_b), .Pending(pend_b),
    .Overrun(ovr_b), .OverrunCount(cnt_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = LSB-first, index 1 = MSB-first.
  logic [7:0] m_pend [2];
  logic [2:0] m_out  [2];
  logic       m_vld  [2];
  logic       m_ovr  [2];
  int         m_cnt  [2];

  task automatic model_step(input int i);
    bit   accepting;
    int   chosen;
    logic [7:0] served;
    int   order [8];
    if (rst) begin
      m_pend[i] = 0; m_out[i] = 0; m_vld[i] = 0; m_ovr[i] = 0; m_cnt[i] = 0;
      return;
    end
    for (int k = 0; k < 8; k++) order[k] = (i == 0) ? k : 7 - k;
    accepting = !m_vld[i] || ready;
    chosen = -1;
    served = 0;
    if (accepting) begin
      for (int k = 0; k < 8; k++)
        if (chosen < 0 && m_pend[i][order[k]]) chosen = order[k];
      if (chosen >= 0) begin
        served[chosen] = 1'b1;
        m_out[i] = 3'(chosen);
        m_vld[i] = 1'b1;
      end else begin
        m_vld[i] = 1'b0;
      end
    end
    m_ovr[i] = ((in_req & m_pend[i] & ~served) != 0);
    if (m_ovr[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
    m_pend[i] = (m_pend[i] & ~served) | in_req;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (started) begin
      check("a.valid",   {31'd0, vld_a}, {31'd0, m_vld[0]});
      if (m_vld[0]) check("a.out", {29'd0, out_a}, {29'd0, m_out[0]});
      check("a.pending", {24'd0, pend_a}, {24'd0, m_pend[0]});
      check("a.overrun", {31'd0, ovr_a}, {31'd0, m_ovr[0]});
      check("a.count",   {24'd0, cnt_a}, m_cnt[0]);
      check("b.valid",   {31'd0, vld_b}, {31'd0, m_vld[1]});
      if (m_vld[1]) check("b.out", {29'd0, out_b}, {29'd0, m_out[1]});
      check("b.pending", {24'd0, pend_b}, {24'd0, m_pend[1]});
      check("b.overrun", {31'd0, ovr_b}, {31'd0, m_ovr[1]});
      check("b.count",   {24'd0, cnt_b}, m_cnt[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [2:0] exp_a [4];
  logic [2:0] exp_b [4];

  initial begin
    rst = 1; in_req = 0; ready = 0;
    tick();
    tick();
    started = 1;
    check("reset.pending", {24'd0, pend_a}, 32'h0);
    check("reset.valid",   {31'd0, vld_a},  32'h0);
    check("reset.out",     {29'd0, out_a},  32'h0);
    check("reset.overrun", {31'd0, ovr_a},  32'h0);
    check("reset.count",   {24'd0, cnt_a},  32'h0);
    rst = 0;
    tick();

    // Single event
    ready = 1; in_req = 8'h04;
    tick();
    in_req = 0;
    check("single.pend_c1", {24'd0, pend_a}, 32'h04);
    check("single.vld_c1",  {31'd0, vld_a},  32'h0);
    tick();
    check("single.vld_c2",  {31'd0, vld_a},  32'h1);
    check("single.out_c2",  {29'd0, out_a},  32'd2);
    check("single.pend_c2", {24'd0, pend_a}, 32'h0);
    tick();
    check("single.vld_c3",  {31'd0, vld_a},  32'h0);
    check("single.hold_out",{29'd0, out_a},  32'd2);

    // Multi-hot burst, both priority orders
    exp_a[0] = 0; exp_a[1] = 2; exp_a[2] = 5; exp_a[3] = 7;
    exp_b[0] = 7; exp_b[1] = 5; exp_b[2] = 2; exp_b[3] = 0;
    in_req = 8'hA5;
    tick();
    in_req = 0;
    tick();
    for (int j = 0; j < 4; j++) begin
      check("burst.a_vld", {31'd0, vld_a}, 32'h1);
      check("burst.a_out", {29'd0, out_a}, {29'd0, exp_a[j]});
      check("burst.b_out", {29'd0, out_b}, {29'd0, exp_b[j]});
      tick();
    end
    check("burst.a_done", {31'd0, vld_a}, 32'h0);
    check("burst.b_done", {31'd0, vld_b}, 32'h0);

    // Backpressure
    ready = 0; in_req = 8'h81;
    tick();
    in_req = 0;
    tick();
    for (int j = 2; j < 6; j++) begin
      check("bp.a_out_held", {29'd0, out_a}, 32'd0);
      check("bp.a_vld_held", {31'd0, vld_a}, 32'h1);
      check("bp.a_pend",     {24'd0, pend_a}, 32'h80);
      check("bp.b_out_held", {29'd0, out_b}, 32'd7);
      tick();
    end
    ready = 1;
    tick();
    check("bp.a_out_c7", {29'd0, out_a}, 32'd7);
    check("bp.a_vld_c7", {31'd0, vld_a}, 32'h1);
    check("bp.b_out_c7", {29'd0, out_b}, 32'd0);
    tick();
    check("bp.a_vld_c8", {31'd0, vld_a}, 32'h0);

    // Overrun
    ready = 0; in_req = 8'h06;
    tick();
    in_req = 0;
    tick();
    check("ovr.a_out",  {29'd0, out_a},  32'd1);
    check("ovr.a_pend", {24'd0, pend_a}, 32'h04);
    check("ovr.b_out",  {29'd0, out_b},  32'd2);
    check("ovr.b_pend", {24'd0, pend_b}, 32'h02);
    tick();
    tick();
    in_req = 8'h04;
    tick();
    in_req = 0;
    check("ovr.a_pulse", {31'd0, ovr_a}, 32'h1);
    check("ovr.a_count", {24'd0, cnt_a}, 32'd1);
    check("ovr.b_pulse", {31'd0, ovr_b}, 32'h0);
    check("ovr.b_count", {24'd0, cnt_b}, 32'd0);
    tick();
    check("ovr.a_pulse_end", {31'd0, ovr_a}, 32'h0);
    ready = 1;
    repeat (4) tick();
    check("ovr.a_drained", {31'd0, vld_a}, 32'h0);

    // Set dominates clear
    in_req = 8'h08;
    tick();
    check("sdc.pend_c1", {24'd0, pend_a}, 32'h08);
    tick();
    in_req = 0;
    check("sdc.vld_c2",  {31'd0, vld_a},  32'h1);
    check("sdc.out_c2",  {29'd0, out_a},  32'd3);
    check("sdc.pend_c2", {24'd0, pend_a}, 32'h08);
    check("sdc.no_ovr",  {31'd0, ovr_a},  32'h0);
    tick();
    check("sdc.out_c3",  {29'd0, out_a},  32'd3);
    check("sdc.vld_c3",  {31'd0, vld_a},  32'h1);
    check("sdc.count",   {24'd0, cnt_a},  32'd1);
    tick();
    check("sdc.vld_c4",  {31'd0, vld_a},  32'h0);

    // Saturation
    ready = 0; in_req = 8'h01;
    repeat (300) tick();
    check("sat.a_count", {24'd0, cnt_a}, 32'd255);
    check("sat.b_count", {24'd0, cnt_b}, 32'd255);
    check("sat.a_pulse", {31'd0, ovr_a}, 32'h1);
    repeat (3) tick();
    check("sat.a_hold",   {24'd0, cnt_a}, 32'd255);
    check("sat.a_pulse2", {31'd0, ovr_a}, 32'h1);

    // Reset mid-operation
    in_req = 8'hFF;
    tick();
    check("rmid.a_pend", {24'd0, pend_a}, 32'hFF);
    check("rmid.a_vld",  {31'd0, vld_a},  32'h1);
    rst = 1;
    tick();
    rst = 0; in_req = 0;
    check("rmid.pend",  {24'd0, pend_a}, 32'h0);
    check("rmid.vld",   {31'd0, vld_a},  32'h0);
    check("rmid.out",   {29'd0, out_a},  32'd0);
    check("rmid.ovr",   {31'd0, ovr_a},  32'h0);
    check("rmid.count", {24'd0, cnt_a},  32'd0);
    ready = 1;
    repeat (3) begin
      tick();
      check("rmid.no_stale_a", {31'd0, vld_a}, 32'h0);
      check("rmid.no_stale_b", {31'd0, vld_b}, 32'h0);
    end

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 15) == 0) in_req = 8'hFF;
      else in_req = 8'($urandom & $urandom & $urandom);
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; in_req = 0; ready = 1;
    repeat (12) tick();
    check("final.a_idle", {31'd0, vld_a}, 32'h0);
    check("final.b_idle", {31'd0, vld_b}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
